fib_seq_engine: RTL
===================

# fib_seq_engine

Parametrised successor to the project_1 Fibonacci calculator. It computes term n of a generalised Fibonacci recurrence, T(k) = T(k-1) + T(k-2), from caller-supplied seeds T(0) and T(1), so Fibonacci, Lucas and arbitrary seeded sequences all run on the same block. It adds configurable data and index width, a per-run overflow flag, abort, and a one-cycle done strobe with a held result. It sits as a leaf compute block under a testbench or controller that drives start/operands and samples done/result.

## Interface
Parameters:
- WIDTH, 16: data width of seeds, terms and result.
- IDX_W, 5: width of term index n; max n = 2^IDX_W − 1.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request a run; sampled on rising edge when ready=1.
- abort  in  1  cancel a run in progress; synchronous.
- n  in  IDX_W  term index to compute; latched on accepted start.
- seed0  in  WIDTH  T(0); latched on accepted start.
- seed1  in  WIDTH  T(1); latched on accepted start.
- ready  out  1  high in IDLE and DONE (start will be accepted).
- busy  out  1  high in COMPUTE.
- done  out  1  one-cycle strobe: result and overflow are valid.
- result  out  WIDTH  T(n); held from done until next accepted start.
- overflow  out  1  some term T(2..n) exceeded WIDTH bits; held with result.

## Operation
- Registers: A (holds T(k)), B (holds T(k+1)), cnt (IDX_W bits), ovfA and ovfB (per-term overflow tags), state.
- States:
  - IDLE: on start with abort=0, load A=seed0, B=seed1, cnt=n, clear ovfA and ovfB, go to COMPUTE.
  - COMPUTE:
    - If cnt≠0: A←B; B←A+B; ovfA←ovfB; ovfB←carry|ovfA|ovfB; cnt←cnt−1.
    - If cnt=0: result←A, overflow←ovfA, done←1, go to DONE.
  - DONE: done←0. On start, load as in IDLE and go to COMPUTE; otherwise go to IDLE.
- Arithmetic: the sum is WIDTH+1 bits. The MSB is the carry. The stored value is the low WIDTH bits, or the saturated value (see Configuration).
- The overflow flag reflects only terms up to T(n). Overflow in T(n+1), which is computed in B but never used, must not set the flag.
- start while busy=1: ignored, no effect.
- abort in COMPUTE: go to IDLE at the next edge. No done pulse; result and overflow keep their previous values.
- abort and start in the same cycle in IDLE or DONE: abort wins and start is ignored. Otherwise abort has no effect in IDLE or DONE.
- reset_n low at any time, including mid-run: immediate return to IDLE, all outputs at reset values.

## Timing
- Reset values: ready=1, busy=0, done=0, result=0, overflow=0, state=IDLE. A, B and cnt are cleared to 0.
- Latency: start is accepted at edge E. busy is high from E to E+n+1. done is high for exactly the cycle after edge E+n+1. For n=0, done follows 1 cycle after acceptance.
- Back-to-back runs: a start asserted during the done cycle is accepted. busy rises again at the next edge with no IDLE gap.
- result and overflow change only at the edge that raises done.

## Configuration
- FIBO_SATURATE_EN defined: any carry makes the stored term all-ones (2^WIDTH−1). Subsequent sums involving it also saturate.
- FIBO_SATURATE_EN undefined: terms wrap modulo 2^WIDTH.
- overflow reporting is identical in both builds.

## Test plan
- seeds 0/1, n=10, WIDTH=16 -> done exactly 11 cycles after acceptance, result=55, overflow=0.
- seeds 0/1, n=0 and n=1 -> result=0 (done 1 cycle after acceptance) and result=1 (done 2 cycles after acceptance).
- seeds 2/1 (Lucas), n=5 -> result=11. start pulsed while busy is ignored, and exactly one done pulse is produced.
- seeds 0/1, n=24 -> result=46368, overflow=0 (T(25) overflow is not flagged). n=25 -> overflow=1, result=9489 when wrapping, or 65535 with FIBO_SATURATE_EN.
- n=20 run, abort asserted at cycle 5 -> no done pulse, previous result held, ready=1 next cycle. start+abort together in IDLE -> no run.
- reset_n dropped mid-run (asynchronously, between edges) -> all outputs reach reset values immediately. After release, a new n=10 run returns 55.

Source files
------------

// File: rtl/fib_seq_engine.sv
// Generalised Fibonacci engine: T(n) from seeds T(0), T(1), with overflow tag.
// Define FIBO_SATURATE_EN to saturate terms on carry instead of wrapping.
module fib_seq_engine #(
    parameter int WIDTH = 16,
    parameter int IDX_W = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             abort,
    input  logic [IDX_W-1:0] n,
    input  logic [WIDTH-1:0] seed0,
    input  logic [WIDTH-1:0] seed1,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             overflow
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COMPUTE,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [IDX_W-1:0] r_cnt;
    logic             r_ovf_a;
    logic             r_ovf_b;
    logic             r_ready;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_result;
    logic             r_overflow;

    logic [WIDTH:0]   w_sum;
    logic             w_carry;
    logic [WIDTH-1:0] w_next;
    logic             w_accept;

    assign w_sum   = {1'b0, r_a} + {1'b0, r_b};
    assign w_carry = w_sum[WIDTH];

`ifdef FIBO_SATURATE_EN
    assign w_next = w_carry ? {WIDTH{1'b1}} : w_sum[WIDTH-1:0];
`else
    assign w_next = w_sum[WIDTH-1:0];
`endif

    // abort beats start when both arrive while idle or done
    assign w_accept = start && !abort
                   && (r_state == S_IDLE || r_state == S_DONE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_a        <= '0;
            r_b        <= '0;
            r_cnt      <= '0;
            r_ovf_a    <= 1'b0;
            r_ovf_b    <= 1'b0;
            r_ready    <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_result   <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_accept) begin
                        r_a     <= seed0;
                        r_b     <= seed1;
                        r_cnt   <= n;
                        r_ovf_a <= 1'b0;
                        r_ovf_b <= 1'b0;
                        r_state <= S_COMPUTE;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                S_COMPUTE: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                    end else if (r_cnt != '0) begin
                        r_a     <= r_b;
                        r_b     <= w_next;
                        r_ovf_a <= r_ovf_b;
                        r_ovf_b <= w_carry | r_ovf_a | r_ovf_b;
                        r_cnt   <= r_cnt - 1'b1;
                    end else begin
                        // ovf_b covers T(n+1) and is deliberately not reported
                        r_result   <= r_a;
                        r_overflow <= r_ovf_a;
                        r_done     <= 1'b1;
                        r_state    <= S_DONE;
                        r_ready    <= 1'b1;
                        r_busy     <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign ready    = r_ready;
    assign busy     = r_busy;
    assign done     = r_done;
    assign result   = r_result;
    assign overflow = r_overflow;

endmodule
